// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
// Digit width, default digit count, and the add-3 and saturation digit values.
package bin_to_bcd_seq_pkg;

    localparam int          DIGIT_W       = 4;
    localparam int          DEF_DIGITS    = 4;
    localparam logic [3:0]  DIGIT_SAT     = 4'd9;
    localparam logic [3:0]  DIGIT_ADJ_MIN = 4'd5;
    localparam logic [3:0]  DIGIT_ADJ_ADD = 4'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more; combinational.
// Carries are dropped on purpose, so digits never interact.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= DIGIT_ADJ_MIN) begin
            dout = din + DIGIT_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter; done pulses BIN_W cycles after start is accepted.
// start is taken only in IDLE (ignored, not queued, while busy); the result is held between conversions.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                    overflow
);

    localparam int SCR_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic               ovf_scr_q, ovf_scr_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [SCR_W-1:0]   scr_adj;
    logic [SCR_W-1:0]   scr_shl;
    logic               carry_out;
    logic               ovf_final;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scr_q  [g*DIGIT_W +: DIGIT_W]),
            .dout (scr_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // A 1 leaving the top digit means the partial value has reached 10^DIGITS.
    assign carry_out = scr_adj[SCR_W-1];
    assign scr_shl   = {scr_adj[SCR_W-2:0], shift_q[BIN_W-1]};
    assign ovf_final = ovf_scr_q | carry_out;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        scr_d     = scr_q;
        ovf_scr_d = ovf_scr_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scr_d     = '0;
                    ovf_scr_d = 1'b0;
                    count_d   = '0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                scr_d     = scr_shl;
                shift_d   = {shift_q[BIN_W-2:0], 1'b0};
                ovf_scr_d = ovf_final;
                count_d   = count_q + CNT_W'(1);
                if (count_q == CNT_W'(BIN_W - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    ovf_d   = ovf_final;
                    bcd_d   = ovf_final ? {DIGITS{DIGIT_SAT}} : scr_shl;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            shift_q   <= '0;
            scr_q     <= '0;
            ovf_scr_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            scr_q     <= scr_d;
            ovf_scr_q <= ovf_scr_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q == ST_CONV);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule
